modulo_controlador_rolhas: RTL and testbench

//   Controller for the 7-bit cork-stock register (bank of D flip-flops with clk/clr/enable).

---
 rtl/modulo_controlador_rolhas.sv | 147 ++++++++++++++
 tb/tb_modulo_controlador_rolhas.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/modulo_controlador_rolhas.sv
`default_nettype none
// ============================================================================
// modulo_controlador_rolhas : write-port controller for the cork-stock register
//   (start load, per-bottle decrement, timed saturating refill, empty alarm)
// Revision: 1.0
// ============================================================================
module modulo_controlador_rolhas #(
  parameter int WIDTH         = 7,
  parameter int INIT_ROLHAS   = 20,
  parameter int MAX_ROLHAS    = 99,
  parameter int LIMIAR        = 5,
  parameter int LOTE          = 15,
  parameter int REFILL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             cap_req,
  input  logic             refill_ok,
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] reg_d,
  output logic             reg_enable,
  output logic             cap_ack,
  output logic             refill_busy,
  output logic             alarm
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_CAP    = 3'd3;
  localparam logic [2:0] S_REFILL = 3'd4;
  localparam logic [2:0] S_LOAD   = 3'd5;
  localparam logic [2:0] S_ALARM  = 3'd6;

  localparam int CW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(REFILL_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT_ROLHAS);
  localparam logic [WIDTH-1:0] LIMIAR_W = WIDTH'(LIMIAR);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_ROLHAS);
  localparam logic [WIDTH:0]   LOTE_X   = (WIDTH+1)'(LOTE);
  localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX_ROLHAS);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_armed_q, req_armed_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             reg_enable_q, reg_enable_d;
  logic             cap_ack_q, cap_ack_d;
  logic             refill_busy_q, refill_busy_d;
  logic             alarm_q, alarm_d;

  // One extra bit so the refill sum cannot wrap before saturation.
  logic [WIDTH:0]   refill_sum;
  logic [WIDTH-1:0] refill_val;

  assign refill_sum = {1'b0, reg_q} + LOTE_X;
  assign refill_val = (refill_sum > MAX_X) ? MAX_W : refill_sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_armed_q   <= 1'b1;
      reg_d_q       <= '0;
      reg_enable_q  <= 1'b0;
      cap_ack_q     <= 1'b0;
      refill_busy_q <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_armed_q   <= req_armed_d;
      reg_d_q       <= reg_d_d;
      reg_enable_q  <= reg_enable_d;
      cap_ack_q     <= cap_ack_d;
      refill_busy_q <= refill_busy_d;
      alarm_q       <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_INIT;
      S_INIT:   state_d = S_READY;
      S_READY: begin
        if (stop)                                         state_d = S_IDLE;
        else if ((reg_q < LIMIAR_W) && refill_ok)         state_d = S_REFILL;
        else if ((reg_q == '0) && !refill_ok)             state_d = S_ALARM;
        else if (cap_req && req_armed_q && (reg_q != '0)) state_d = S_CAP;
      end
      S_CAP:    state_d = S_READY;
      S_REFILL: if (cnt_q == CNT_LAST) state_d = S_LOAD;
      S_LOAD:   state_d = S_READY;
      S_ALARM: begin
        if (stop)           state_d = S_IDLE;
        else if (refill_ok) state_d = S_READY;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Counter is zero everywhere except inside REFILL, so entry always starts at 0.
  always_comb begin
    cnt_d = (state_q == S_REFILL) ? cnt_q + 1'b1 : '0;
    if (!cap_req)              req_armed_d = 1'b1;
    else if (state_q == S_CAP) req_armed_d = 1'b0;
    else                       req_armed_d = req_armed_q;
  end

  // Outputs are registered from the upcoming state, so they are valid for the whole state.
  always_comb begin
    reg_d_d       = '0;
    reg_enable_d  = 1'b0;
    cap_ack_d     = 1'b0;
    refill_busy_d = 1'b0;
    alarm_d       = 1'b0;
    case (state_d)
      S_INIT: begin
        reg_enable_d = 1'b1;
        reg_d_d      = INIT_W;
      end
      S_CAP: begin
        reg_enable_d = 1'b1;
        reg_d_d      = reg_q - 1'b1;
        cap_ack_d    = 1'b1;
      end
      S_REFILL: refill_busy_d = 1'b1;
      S_LOAD: begin
        reg_enable_d = 1'b1;
        reg_d_d      = refill_val;
      end
      S_ALARM:  alarm_d = 1'b1;
      default: ;
    endcase
  end

  assign reg_d       = reg_d_q;
  assign reg_enable  = reg_enable_q;
  assign cap_ack     = cap_ack_q;
  assign refill_busy = refill_busy_q;
  assign alarm       = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_modulo_controlador_rolhas.sv
`default_nettype none
// Bench for modulo_controlador_rolhas: cork register model, behavioural reference, directed scenarios.
module tb_modulo_controlador_rolhas;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 0, stop = 0, cap_req = 0, refill_ok = 0;
  logic [6:0] reg_q = '0, reg_d;
  logic       reg_enable, cap_ack, refill_busy, alarm;
  logic       force_en = 0;
  logic [6:0] force_val = '0;

  logic       start2 = 0, refill_ok2 = 0, force2_en = 0;
  logic [6:0] reg_q2 = '0, reg_d2;
  logic       reg_enable2, cap_ack2, refill_busy2, alarm2;

  int n_chk = 0, n_err = 0;
  int ack_cnt = 0, busy_cnt = 0;
  int wr_log[$];

  always #5 clk = ~clk;

  modulo_controlador_rolhas dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .cap_req(cap_req),
    .refill_ok(refill_ok), .reg_q(reg_q), .reg_d(reg_d), .reg_enable(reg_enable),
    .cap_ack(cap_ack), .refill_busy(refill_busy), .alarm(alarm)
  );

  modulo_controlador_rolhas #(.LIMIAR(95)) dut2 (
    .clk(clk), .clr(clr), .start(start2), .stop(1'b0), .cap_req(1'b0),
    .refill_ok(refill_ok2), .reg_q(reg_q2), .reg_d(reg_d2), .reg_enable(reg_enable2),
    .cap_ack(cap_ack2), .refill_busy(refill_busy2), .alarm(alarm2)
  );

  // Cork-stock registers (cleared by clr); force lets the bench preset a count.
  always @(posedge clk or negedge clr)
    if (!clr)            reg_q <= '0;
    else if (force_en)   reg_q <= force_val;
    else if (reg_enable) reg_q <= reg_d;

  always @(posedge clk or negedge clr)
    if (!clr)             reg_q2 <= '0;
    else if (force2_en)   reg_q2 <= 7'd90;
    else if (reg_enable2) reg_q2 <= reg_d2;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: operating mode plus the stock count it believes the register holds.
  localparam int M_IDLE = 0, M_INIT = 1, M_READY = 2, M_CAP = 3,
                 M_REFILL = 4, M_LOAD = 5, M_ALARM = 6;
  int m_mode = M_IDLE, m_cnt = 0, m_wait = 0, m_old, m_nxt;
  bit m_armed = 1;

  function automatic int refilled(input int c);
    return (c + 15 > 99) ? 99 : c + 15;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_mode = M_IDLE; m_cnt = 0; m_wait = 0; m_armed = 1;
    end else begin
      m_old = m_cnt;
      m_nxt = m_mode;
      case (m_mode)
        M_IDLE:  if (start) m_nxt = M_INIT;
        M_INIT:  m_nxt = M_READY;
        M_READY: begin
          if (stop) m_nxt = M_IDLE;
          else if (m_old < 5 && refill_ok) begin m_nxt = M_REFILL; m_wait = 4; end
          else if (m_old == 0 && !refill_ok) m_nxt = M_ALARM;
          else if (cap_req && m_armed && m_old > 0) m_nxt = M_CAP;
        end
        M_CAP:    m_nxt = M_READY;
        M_REFILL: begin m_wait--; if (m_wait == 0) m_nxt = M_LOAD; end
        M_LOAD:   m_nxt = M_READY;
        M_ALARM:  if (stop) m_nxt = M_IDLE; else if (refill_ok) m_nxt = M_READY;
        default:  m_nxt = M_IDLE;
      endcase
      case (m_mode)
        M_INIT:  m_cnt = 20;
        M_CAP:   m_cnt = m_old - 1;
        M_LOAD:  m_cnt = refilled(m_old);
        default: ;
      endcase
      if (force_en) m_cnt = force_val;
      if (!cap_req) m_armed = 1;
      else if (m_mode == M_CAP) m_armed = 0;
      m_mode = m_nxt;
    end
  end

  always @(negedge clk) begin
    int e_d;
    e_d = (m_mode == M_INIT) ? 20 : (m_mode == M_CAP) ? m_cnt - 1 :
          (m_mode == M_LOAD) ? refilled(m_cnt) : 0;
    chk("reg_enable", int'(reg_enable), int'(m_mode inside {M_INIT, M_CAP, M_LOAD}));
    chk("reg_d", int'(reg_d), e_d);
    chk("cap_ack", int'(cap_ack), int'(m_mode == M_CAP));
    chk("refill_busy", int'(refill_busy), int'(m_mode == M_REFILL));
    chk("alarm", int'(alarm), int'(m_mode == M_ALARM));
    chk("reg_q", int'(reg_q), m_cnt);
    if (cap_ack) ack_cnt++;
    if (refill_busy) busy_cnt++;
    if (clr && reg_enable) wr_log.push_back(int'(reg_d));
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  int a0, b0, w0;

  initial begin
    #1 clr = 0;
    // Reset and initial load
    cyc(2);
    chk("rst_reg_enable", int'(reg_enable), 0);
    chk("rst_reg_d", int'(reg_d), 0);
    clr = 1;
    cyc(1);
    start = 1;
    cyc(1);
    chk("init_enable", int'(reg_enable), 1);
    chk("init_reg_d", int'(reg_d), 20);
    start = 0;
    cyc(1);
    chk("init_reg_q", int'(reg_q), 20);

    // One cork per request pulse
    a0 = ack_cnt;
    cap_req = 1; cyc(5); cap_req = 0;
    chk("held_req_acks", ack_cnt - a0, 1);
    chk("held_req_reg_q", int'(reg_q), 19);
    cyc(2);
    cap_req = 1; cyc(3); cap_req = 0; cyc(1);
    chk("second_req_acks", ack_cnt - a0, 2);
    chk("second_req_reg_q", int'(reg_q), 18);

    // Low stock: refill wins over pending request
    force_val = 7'd4; force_en = 1; cyc(1); force_en = 0;
    chk("forced_4", int'(reg_q), 4);
    a0 = ack_cnt; b0 = busy_cnt; w0 = wr_log.size();
    refill_ok = 1; cap_req = 1; cyc(2); refill_ok = 0; cyc(8); cap_req = 0; cyc(1);
    chk("refill_busy_cycles", busy_cnt - b0, 4);
    chk("refill_writes", wr_log.size() - w0, 2);
    if (wr_log.size() - w0 == 2) begin
      chk("load_value", wr_log[w0], 19);
      chk("cap_after_load", wr_log[w0 + 1], 18);
    end
    chk("refill_ack", ack_cnt - a0, 1);
    chk("refill_reg_q", int'(reg_q), 18);

    // Empty stock alarm, then recovery
    force_val = 7'd0; force_en = 1; cyc(1); force_en = 0;
    a0 = ack_cnt;
    cap_req = 1; cyc(3);
    chk("alarm_high", int'(alarm), 1);
    chk("alarm_no_ack", ack_cnt - a0, 0);
    refill_ok = 1; cyc(1);
    chk("alarm_cleared", int'(alarm), 0);
    cyc(1); refill_ok = 0; cyc(8); cap_req = 0; cyc(1);
    chk("alarm_recover_ack", ack_cnt - a0, 1);
    chk("alarm_recover_reg_q", int'(reg_q), 14);

    // Stop returns to IDLE; requests ignored there; restart reloads
    a0 = ack_cnt;
    stop = 1; cyc(1); stop = 0;
    cap_req = 1; cyc(3); cap_req = 0;
    chk("idle_no_ack", ack_cnt - a0, 0);
    start = 1; cyc(1); start = 0; cyc(1);
    chk("restart_reg_q", int'(reg_q), 20);

    // Reset mid-refill aborts without a write
    force_val = 7'd3; force_en = 1; cyc(1); force_en = 0;
    refill_ok = 1; cyc(2);
    chk("pre_abort_busy", int'(refill_busy), 1);
    clr = 0; #1;
    chk("abort_busy", int'(refill_busy), 0);
    chk("abort_enable", int'(reg_enable), 0);
    chk("abort_reg_q", int'(reg_q), 0);
    w0 = wr_log.size();
    refill_ok = 0; cyc(2); clr = 1; cyc(6);
    chk("abort_no_write", wr_log.size() - w0, 0);
    chk("abort_stays_idle", int'(reg_q), 0);

    // Saturation at MAX_ROLHAS (second instance, threshold 95)
    start2 = 1; cyc(1); start2 = 0; cyc(1);
    chk("dut2_init", int'(reg_q2), 20);
    force2_en = 1; cyc(1); force2_en = 0;
    chk("dut2_forced", int'(reg_q2), 90);
    refill_ok2 = 1; cyc(1); refill_ok2 = 0;
    chk("dut2_busy", int'(refill_busy2), 1);
    cyc(4);
    chk("dut2_load_enable", int'(reg_enable2), 1);
    chk("dut2_load_sat", int'(reg_d2), 99);
    cyc(1);
    chk("dut2_reg_q", int'(reg_q2), 99);
    chk("dut2_enable_off", int'(reg_enable2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
